// File: rtl/caption_rle_encoder.sv
// Caption overlay encoder: RGB+alpha pixels -> 4-bit grayscale palette index -> run-length bytes.
// Three stages (luma, quantise, RLE) advance together whenever the output byte slot is free.
module caption_rle_encoder #(
  parameter int MAX_RUN = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  input  logic [23:0] i_pix_rgb,
  input  logic        i_pix_alpha,
  input  logic        i_pix_last,
  output logic        o_rle_valid,
  input  logic        i_rle_ready,
  output logic [7:0]  o_rle_data,
  output logic        o_rle_last,
  output logic [1:0]  o_state
);

  // Handshakes: a pixel transfers on a rising edge with i_pix_valid && o_pix_ready;
  // a byte transfers with o_rle_valid && i_rle_ready, and is held stable until then.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] MAX_LEN = 5'(MAX_RUN);

  state_t      state, state_nx;
  logic        adv;
  logic        rst_done;
  logic [9:0]  luma_sum;
  logic [7:0]  luma_gray;
  logic        s1_valid, s1_alpha, s1_last;
  logic [7:0]  s1_gray;
  logic [3:0]  q_idx;
  logic        s2_valid, s2_last;
  logic [3:0]  s2_idx;
  logic [3:0]  cur_idx, cur_idx_nx;
  logic [4:0]  cur_len, cur_len_nx;
  logic [3:0]  len_m1;
  logic        emit, emit_last;
  logic [7:0]  emit_data;

  assign adv         = !o_rle_valid || i_rle_ready;
  assign o_pix_ready = rst_done && adv && (state != FLUSH);
  assign o_state     = state;

  assign luma_sum  = {2'b00, i_pix_rgb[23:16]} + {1'b0, i_pix_rgb[15:8], 1'b0}
                   + {2'b00, i_pix_rgb[7:0]} + 10'd2;
  assign luma_gray = 8'(luma_sum >> 2);
  assign len_m1    = 4'(cur_len - 5'd1);

  // Decision ranges of the nearest palette entry; ties fall to the lower index.
  always_comb begin
    q_idx = 4'd14;
    if (!s1_alpha)               q_idx = 4'd0;
    else if (s1_gray >= 8'd253)  q_idx = 4'd1;
    else if (s1_gray >= 8'd250)  q_idx = 4'd3;
    else if (s1_gray >= 8'd244)  q_idx = 4'd4;
    else if (s1_gray >= 8'd233)  q_idx = 4'd5;
    else if (s1_gray >= 8'd214)  q_idx = 4'd6;
    else if (s1_gray >= 8'd183)  q_idx = 4'd7;
    else if (s1_gray >= 8'd140)  q_idx = 4'd8;
    else if (s1_gray >= 8'd90)   q_idx = 4'd9;
    else if (s1_gray >= 8'd46)   q_idx = 4'd10;
    else if (s1_gray >= 8'd17)   q_idx = 4'd11;
    else if (s1_gray >= 8'd4)    q_idx = 4'd12;
    else if (s1_gray >= 8'd1)    q_idx = 4'd13;
  end

  // Stages 1-2 freeze during FLUSH so the pixel behind a frame's last one waits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_done <= 1'b0;
      s1_valid <= 1'b0;
      s1_alpha <= 1'b0;
      s1_last  <= 1'b0;
      s1_gray  <= 8'h00;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_idx   <= 4'h0;
    end else begin
      rst_done <= 1'b1;
      if (adv && state != FLUSH) begin
        s1_valid <= i_pix_valid && rst_done;
        s1_alpha <= i_pix_alpha;
        s1_last  <= i_pix_last;
        s1_gray  <= luma_gray;
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
        s2_idx   <= q_idx;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cur_idx_nx = cur_idx;
    cur_len_nx = cur_len;
    emit       = 1'b0;
    emit_data  = 8'h00;
    emit_last  = 1'b0;
    case (state)
      IDLE: begin
        if (s2_valid) begin
          if (s2_last) begin
            emit      = 1'b1;
            emit_data = {4'h0, s2_idx};
            emit_last = 1'b1;
          end else begin
            cur_idx_nx = s2_idx;
            cur_len_nx = 5'd1;
            state_nx   = RUN;
          end
        end
      end
      RUN: begin
        if (s2_valid) begin
          if (s2_idx == cur_idx && cur_len < MAX_LEN) begin
            if (s2_last) begin
              emit      = 1'b1;
              emit_data = {cur_len[3:0], s2_idx};
              emit_last = 1'b1;
              state_nx  = IDLE;
            end else begin
              cur_len_nx = cur_len + 5'd1;
            end
          end else begin
            // Close the pending run; a last pixel here needs its own byte next cycle.
            emit       = 1'b1;
            emit_data  = {len_m1, cur_idx};
            cur_idx_nx = s2_idx;
            cur_len_nx = 5'd1;
            state_nx   = s2_last ? FLUSH : RUN;
          end
        end
      end
      FLUSH: begin
        emit      = 1'b1;
        emit_data = {4'h0, cur_idx};
        emit_last = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cur_idx     <= 4'h0;
      cur_len     <= 5'd0;
      o_rle_valid <= 1'b0;
      o_rle_data  <= 8'h00;
      o_rle_last  <= 1'b0;
    end else if (adv) begin
      state       <= state_nx;
      cur_idx     <= cur_idx_nx;
      cur_len     <= cur_len_nx;
      o_rle_valid <= emit;
      if (emit) begin
        o_rle_data <= emit_data;
        o_rle_last <= emit_last;
      end
    end
  end

endmodule

// File: tb/tb_caption_rle_encoder.sv
// Bench for caption_rle_encoder: directed scenarios plus random frames scored against
// a frame-level model (luma formula, decision table, run grouping capped at MAX_RUN).
module tb_caption_rle_encoder;

  typedef struct packed {
    logic [23:0] rgb;
    logic        alpha;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_rgb = 24'h0;
  logic        pix_alpha = 1'b0;
  logic        pix_last = 1'b0;
  logic        rle_ready = 1'b1;
  logic        sel4 = 1'b0;

  logic        ready16, valid16, last16, ready4, valid4, last4;
  logic [7:0]  data16, data4;
  logic [1:0]  st16, st4;
  logic        pix_ready, o_valid, o_last;
  logic [7:0]  o_data;

  pix_t        frame_q[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  int          checks = 0;
  int          passes = 0;
  int          stab_err = 0;
  int          sink_mode = 0;
  logic        prev_stalled = 1'b0;
  logic [7:0]  prev_data = 8'h0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  assign pix_ready = sel4 ? ready4 : ready16;
  assign o_valid   = sel4 ? valid4 : valid16;
  assign o_data    = sel4 ? data4  : data16;
  assign o_last    = sel4 ? last4  : last16;

  caption_rle_encoder #(.MAX_RUN(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_pix_valid(pix_valid & ~sel4), .o_pix_ready(ready16),
    .i_pix_rgb(pix_rgb), .i_pix_alpha(pix_alpha), .i_pix_last(pix_last),
    .o_rle_valid(valid16), .i_rle_ready(rle_ready), .o_rle_data(data16),
    .o_rle_last(last16), .o_state(st16)
  );

  caption_rle_encoder #(.MAX_RUN(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_pix_valid(pix_valid & sel4), .o_pix_ready(ready4),
    .i_pix_rgb(pix_rgb), .i_pix_alpha(pix_alpha), .i_pix_last(pix_last),
    .o_rle_valid(valid4), .i_rle_ready(rle_ready), .o_rle_data(data4),
    .o_rle_last(last4), .o_state(st4)
  );

  // Sink: ready changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (sink_mode)
      0:       rle_ready = 1'b1;
      1:       rle_ready = 1'($urandom_range(0, 1));
      default: rle_ready = 1'b0;
    endcase
  end

  // Monitor: capture transferred bytes, flag unstable stalled bytes or input accepted while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled && (!o_valid || o_data !== prev_data || o_last !== prev_last)) stab_err++;
      if (o_valid && !rle_ready && pix_ready) stab_err++;
      if (o_valid && rle_ready) got_q.push_back({o_last, o_data});
      prev_stalled = o_valid && !rle_ready;
      prev_data    = o_data;
      prev_last    = o_last;
    end
  end

  function automatic logic [3:0] ref_index(input logic [23:0] rgb, input logic alpha);
    int g;
    int lo[12];
    int ix[12];
    lo = '{253, 250, 244, 233, 214, 183, 140, 90, 46, 17, 4, 1};
    ix = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    if (!alpha) return 4'd0;
    g = (int'(rgb[23:16]) + 2 * int'(rgb[15:8]) + int'(rgb[7:0]) + 2) / 4;
    for (int i = 0; i < 12; i++) if (g >= lo[i]) return 4'(ix[i]);
    return 4'd14;
  endfunction

  // Expected bytes of the frame in frame_q: maximal equal-index runs, capped at the run limit.
  task automatic model_frame();
    int n, i, len, max_run;
    logic [3:0] idx[$];
    max_run = sel4 ? 4 : 16;
    n = frame_q.size();
    foreach (frame_q[k]) idx.push_back(ref_index(frame_q[k].rgb, frame_q[k].alpha));
    i = 0;
    while (i < n) begin
      len = 1;
      while (i + len < n && idx[i + len] == idx[i] && len < max_run) len++;
      exp_q.push_back({(i + len == n), 4'(len - 1), idx[i]});
      i += len;
    end
  endtask

  task automatic drive_pixel(input pix_t p, input logic last);
    int budget = 0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_rgb   = p.rgb;
    pix_alpha = p.alpha;
    pix_last  = last;
    while (!pix_ready && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 1000) begin
      checks++;
      $display("FAIL pix_accept_timeout: pix_ready stayed %b, required 1", pix_ready);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic send_frame();
    model_frame();
    foreach (frame_q[k]) drive_pixel(frame_q[k], k == frame_q.size() - 1);
    frame_q.delete();
  endtask

  task automatic wait_drain(input int n);
    int b = 0;
    while (got_q.size() < n && b < 3000) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_sb();
    @(posedge clk);
    exp_q.delete();
    got_q.delete();
    frame_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_valid, o_data, o_last, pix_ready} !== 11'h0)
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b ready=%b, required all 0",
               o_valid, o_data, o_last, pix_ready);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b0) $display("FAIL ready_during_release: got %b required 0", pix_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) $display("FAIL ready_after_release: got %b required 1", pix_ready);
    else passes++;
  endtask

  task automatic test_single_white();
    sink_mode = 0;
    clear_sb();
    drive_pixel('{rgb: 24'hFFFFFF, alpha: 1'b1}, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) $display("FAIL white_early: valid=%b before edge k+2, required 0", o_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if ({o_valid, o_last, o_data} !== 10'h301)
      $display("FAIL white_byte: got valid=%b last=%b data=%h, required 1 1 01", o_valid, o_last, o_data);
    else passes++;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) $display("FAIL white_single: valid=%b after byte, required 0", o_valid);
    else passes++;
  endtask

  task automatic test_run_split();
    logic [8:0] want16[2];
    want16 = '{9'h0F9, 9'h139};
    sink_mode = 0;
    clear_sb();
    repeat (20) frame_q.push_back('{rgb: 24'h808080, alpha: 1'b1});
    foreach (frame_q[k]) drive_pixel(frame_q[k], k == 19);
    frame_q.delete();
    wait_drain(2);
    checks++;
    if (got_q.size() !== 2) $display("FAIL split16_count: got %0d bytes required 2", got_q.size());
    else passes++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== want16[i])
        $display("FAIL split16[%0d]: got %h required %h", i, (got_q.size() > i) ? got_q[i] : 9'h0, want16[i]);
      else passes++;
    end
    sel4 = 1'b1;
    clear_sb();
    for (int k = 0; k < 20; k++) drive_pixel('{rgb: 24'h808080, alpha: 1'b1}, k == 19);
    wait_drain(5);
    checks++;
    if (got_q.size() !== 5) $display("FAIL split4_count: got %0d bytes required 5", got_q.size());
    else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== ((i == 4) ? 9'h139 : 9'h039))
        $display("FAIL split4[%0d]: got %h required %h", i, (got_q.size() > i) ? got_q[i] : 9'h0,
                 (i == 4) ? 9'h139 : 9'h039);
      else passes++;
    end
    @(negedge clk);
    sel4 = 1'b0;
  endtask

  task automatic test_threshold_sweep();
    sink_mode = 0;
    clear_sb();
    for (int g = 0; g < 256; g++) begin
      frame_q.push_back('{rgb: {3{8'(g)}}, alpha: 1'b1});
      send_frame();
    end
    wait_drain(256);
    checks++;
    if (got_q.size() !== 256) $display("FAIL sweep_count: got %0d required 256", got_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL sweep[g=%0d]: got %h required %h", i, (got_q.size() > i) ? got_q[i] : 9'h0, exp_q[i]);
      else passes++;
    end
    if (got_q.size() == 256) begin
      checks++;
      if ({got_q[255], got_q[252], got_q[182], got_q[89], got_q[0]} !== {9'h101, 9'h103, 9'h108, 9'h10A, 9'h10E})
        $display("FAIL sweep_spot: got %h %h %h %h %h required 101 103 108 10a 10e",
                 got_q[255], got_q[252], got_q[182], got_q[89], got_q[0]);
      else passes++;
    end
  endtask

  task automatic test_transparency_flush();
    logic [8:0] want[4];
    want = '{9'h020, 9'h11E, 9'h001, 9'h10E};
    sink_mode = 0;
    clear_sb();
    for (int k = 0; k < 3; k++) drive_pixel('{rgb: 24'($urandom), alpha: 1'b0}, 1'b0);
    drive_pixel('{rgb: 24'h000000, alpha: 1'b1}, 1'b0);
    drive_pixel('{rgb: 24'h000000, alpha: 1'b1}, 1'b1);
    drive_pixel('{rgb: 24'hFFFFFF, alpha: 1'b1}, 1'b0);
    drive_pixel('{rgb: 24'h000000, alpha: 1'b1}, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b0) $display("FAIL flush_ready_low: got %b required 0", pix_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) $display("FAIL flush_ready_back: got %b required 1", pix_ready);
    else passes++;
    wait_drain(4);
    checks++;
    if (got_q.size() !== 4) $display("FAIL flush_count: got %0d required 4", got_q.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== want[i])
        $display("FAIL flush[%0d]: got %h required %h", i, (got_q.size() > i) ? got_q[i] : 9'h0, want[i]);
      else passes++;
    end
  endtask

  task automatic build_random_frame();
    logic [23:0] colors[5];
    int len, rep, c;
    pix_t p;
    colors = '{24'h000000, 24'h808080, 24'hFFFFFF, 24'hFF0000, 24'h3050A0};
    len = $urandom_range(1, 40);
    while (frame_q.size() < len) begin
      c = $urandom_range(0, 5);
      p.rgb   = (c == 5) ? 24'($urandom) : colors[c];
      p.alpha = ($urandom_range(0, 7) != 0);
      rep = $urandom_range(1, 20);
      for (int r = 0; r < rep && frame_q.size() < len; r++) frame_q.push_back(p);
    end
  endtask

  task automatic test_random_frames(input int mode, input logic hold);
    sink_mode = mode;
    clear_sb();
    stab_err = 0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          build_random_frame();
          send_frame();
        end
      end
      begin
        if (hold) begin
          repeat (30) @(posedge clk);
          sink_mode = 2;
          repeat (10) @(posedge clk);
          sink_mode = mode;
        end
      end
    join
    wait_drain(exp_q.size());
    checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL random_m%0d_count: got %0d bytes required %0d", mode, got_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL random_m%0d[%0d]: got %h required %h", mode, i,
                 (got_q.size() > i) ? got_q[i] : 9'h0, exp_q[i]);
      else passes++;
    end
    checks++;
    if (stab_err !== 0) $display("FAIL stall_stability_m%0d: %0d violations, required 0", mode, stab_err);
    else passes++;
    sink_mode = 0;
  endtask

  task automatic test_reset_mid_run();
    sink_mode = 0;
    clear_sb();
    for (int k = 0; k < 5; k++) drive_pixel('{rgb: 24'h808080, alpha: 1'b1}, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_valid, o_data, o_last, pix_ready} !== 11'h0)
      $display("FAIL midrst_outputs: got valid=%b data=%h last=%b ready=%b, required all 0",
               o_valid, o_data, o_last, pix_ready);
    else passes++;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() !== 0) $display("FAIL midrst_no_byte: got %0d bytes required 0", got_q.size());
    else passes++;
    repeat (3) frame_q.push_back('{rgb: 24'hFFFFFF, alpha: 1'b1});
    repeat (3) frame_q.push_back('{rgb: 24'h808080, alpha: 1'b1});
    send_frame();
    wait_drain(exp_q.size());
    checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL midrst_count: got %0d required %0d", got_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL midrst[%0d]: got %h required %h", i, (got_q.size() > i) ? got_q[i] : 9'h0, exp_q[i]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_white();
    test_run_split();
    test_threshold_sweep();
    test_transparency_flush();
    test_random_frames(0, 1'b0);
    test_random_frames(1, 1'b1);
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
